rv_test_monitor: RTL

- Synthesizable pass/fail/timeout monitor for core self-test programs.
- Snoops the register-file write port and keeps shadow copies of the "done" register (default s10 = x26) and the "result" register (default s11 = x27).
- Declares PASS or FAIL once "done" has been stable at 1 for a programmable settle window, or TIMEOUT if a cycle budget expires first.
- Sits beside the core in the SoC top; its outputs drive benches, LEDs or a status CSR.

---
 rtl/rv_test_monitor_if.sv | 31 +++
 rtl/rv_test_monitor.sv | 109 ++++++++++
 2 files changed

// File: rtl/rv_test_monitor_if.sv
// Bundle between a core's register-file write port and the self-test monitor.
// Status outputs are driven by the monitor and read by the SoC or bench.
interface rv_test_monitor_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    // rf_we qualifies rf_waddr/rf_wdata in the cycle it is high (valid-only,
    // no ready: the monitor never stalls the core); start is a one-cycle pulse.
    logic              start;
    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [XLEN-1:0]   rf_wdata;
    logic              busy;
    logic              done;
    logic              pass;
    logic              fail;
    logic              timeout;
    logic [XLEN-1:0]   result;
    logic [CNT_W-1:0]  cycle_count;

    modport master (
        output start, rf_we, rf_waddr, rf_wdata,
        input  busy, done, pass, fail, timeout, result, cycle_count
    );

    modport slave (
        input  start, rf_we, rf_waddr, rf_wdata,
        output busy, done, pass, fail, timeout, result, cycle_count
    );
endinterface

// File: rtl/rv_test_monitor.sv
// Pass/fail/timeout monitor for core self-test programs: shadows the "done"
// and "result" registers from the register-file write port and issues a verdict.
module rv_test_monitor #(
    parameter int XLEN           = 32,
    parameter int REG_AW         = 5,
    parameter int DONE_REG       = 26,
    parameter int RESULT_REG     = 27,
    parameter int SETTLE_CYCLES  = 5,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int CNT_W          = 32
) (
    input  logic               clk,
    input  logic               rst,
    rv_test_monitor_if.slave   bus,
    output logic [2:0]         dbg_state
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RUN     = 3'd1;
    localparam logic [2:0] S_SETTLE  = 3'd2;
    localparam logic [2:0] S_PASS    = 3'd3;
    localparam logic [2:0] S_FAIL    = 3'd4;
    localparam logic [2:0] S_TIMEOUT = 3'd5;

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0]     SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TMO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [REG_AW-1:0] DONE_IDX    = REG_AW'(DONE_REG);
    localparam logic [REG_AW-1:0] RES_IDX     = REG_AW'(RESULT_REG);

    logic [2:0]       state;
    logic [XLEN-1:0]  done_sh;
    logic [XLEN-1:0]  res_sh;
    logic [XLEN-1:0]  result_q;
    logic [SW-1:0]    settle_cnt;
    logic [CNT_W-1:0] cycle_cnt;
    logic             active;
    logic             done_is_one;
    logic             verdict;
    logic             tmo;
    logic             wr_ok;

    assign active      = (state == S_RUN) || (state == S_SETTLE);
    assign done_is_one = (done_sh == XLEN'(1));
    assign verdict     = (state == S_SETTLE) && done_is_one && (settle_cnt == SETTLE_LAST);
    // A verdict landing on the last budget cycle takes precedence over timeout.
    assign tmo         = active && (cycle_cnt == TMO_LAST) && !verdict;
    assign wr_ok       = active && bus.rf_we && (bus.rf_waddr != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            done_sh    <= '0;
            res_sh     <= '0;
            result_q   <= '0;
            settle_cnt <= '0;
            cycle_cnt  <= '0;
        end else if (bus.start) begin
            state      <= S_RUN;
            done_sh    <= '0;
            res_sh     <= '0;
            result_q   <= '0;
            settle_cnt <= '0;
            cycle_cnt  <= '0;
        end else begin
            if (wr_ok && (bus.rf_waddr == DONE_IDX)) done_sh <= bus.rf_wdata;
            if (wr_ok && (bus.rf_waddr == RES_IDX))  res_sh  <= bus.rf_wdata;

            // Saturate rather than wrap so an undersized CNT_W never aliases.
            if (active && !verdict && !tmo && (cycle_cnt != '1))
                cycle_cnt <= cycle_cnt + 1'b1;

            case (state)
                S_RUN: begin
                    if (tmo) begin
                        state    <= S_TIMEOUT;
                        result_q <= res_sh;
                    end else if (done_is_one) begin
                        state      <= S_SETTLE;
                        settle_cnt <= '0;
                    end
                end
                S_SETTLE: begin
                    if (verdict) begin
                        state    <= (res_sh == XLEN'(1)) ? S_PASS : S_FAIL;
                        result_q <= res_sh;
                    end else if (tmo) begin
                        state    <= S_TIMEOUT;
                        result_q <= res_sh;
                    end else if (!done_is_one) begin
                        state      <= S_RUN;
                        settle_cnt <= '0;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                default: state <= state;
            endcase
        end
    end

    assign bus.busy        = active;
    assign bus.done        = (state == S_PASS) || (state == S_FAIL) || (state == S_TIMEOUT);
    assign bus.pass        = (state == S_PASS);
    assign bus.fail        = (state == S_FAIL);
    assign bus.timeout     = (state == S_TIMEOUT);
    assign bus.result      = result_q;
    assign bus.cycle_count = cycle_cnt;
    assign dbg_state       = state;
endmodule
